// File: rtl/ic_74hc112_pkg.sv
// Shared types and constants for the single-section 74HC112 JK flip-flop model.
// No logic lives here; the top module uses the J/K action encoding and the clear value.
// Nothing in this package is clocked.
package ic_74hc112_pkg;

    // The {J,K} pair read as a two-bit action code.
    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } jk_mode_t;

    // Value stored while clear is asserted. Clear also wins when set is asserted at the same time.
    localparam logic Q_RESET_VAL = 1'b0;

endpackage

// File: rtl/ic_74hc112.sv
// Purpose: one negative-edge JK flip-flop with async active-low set (S) and clear (R), like one 74HC112 section.
// Latency: Q updates on the falling Clk edge that samples J/K; R/S act immediately without any clock.
// Backpressure: none; this is a free-running leaf cell. Optional macro HC112_SVA_EN adds run-time assertions.
module ic_74hc112
    import ic_74hc112_pkg::*;
(
    input  logic Clk,
    input  logic R,
    input  logic S,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Q_N
);

    logic     q_r;
    jk_mode_t mode;

    assign mode = jk_mode_t'({J, K});

    // Stored bit: clear beats set, and both beat the clocked J/K action.
    always_ff @(negedge Clk or negedge R or negedge S) begin
        if (!R) begin
            q_r <= Q_RESET_VAL;
        end else if (!S) begin
            q_r <= 1'b1;
        end else begin
            case (mode)
                HOLD:    q_r <= q_r;
                RESET:   q_r <= 1'b0;
                SET:     q_r <= 1'b1;
                TOGGLE:  q_r <= ~q_r;
                default: q_r <= q_r;
            endcase
        end
    end

    // Outputs follow the asserted control levels. When R and S are both low, Q and Q_N are both high, as on the real part.
    always_comb begin
        Q   = q_r | ~S;
        Q_N = (~q_r & S) | (~R & ~S);
    end

`ifdef HC112_SVA_EN
    // Holds the value Q had at the last rising edge. At the next falling edge, the pre-edge Q must still match it.
    logic q_at_rise;

    // Captures Q at each rising edge so the stability check has a reference value.
    always_ff @(posedge Clk) begin
        q_at_rise <= Q;
    end

    a_complement_fall : assert property (@(negedge Clk) (R && S) |-> (Q_N == ~Q))
        else $error("ic_74hc112: Q_N not complement of Q at %0t", $time);

    a_complement_rise : assert property (@(posedge Clk) (R && S) |-> (Q_N == ~Q))
        else $error("ic_74hc112: Q_N not complement of Q at %0t", $time);

    a_inputs_known : assert property (@(negedge Clk) !$isunknown({J, K, R, S}))
        else $error("ic_74hc112: unknown J/K/R/S at falling edge, %0t", $time);

    a_q_stable : assert property (@(negedge Clk)
        (R && S && $past(R && S)) |-> (Q == q_at_rise))
        else $error("ic_74hc112: Q changed between falling edges at %0t", $time);
`endif

endmodule

// File: tb/tb_ic_74hc112.sv
// Bench for ic_74hc112 using a directed test-plan table followed by randomized J/K/R/S steps.
// Each step checks Q/Q_N after the rising edge, after the mid-cycle input change, and after the falling edge.
// Expected values come from a behavioural model and pass through a queue to a separate monitor.
`timescale 1ns/1ps
module tb_ic_74hc112;

    logic Clk, R, S, J, K;
    logic Q, Q_N;

    ic_74hc112 dut (
        .Clk (Clk),
        .R   (R),
        .S   (S),
        .J   (J),
        .K   (K),
        .Q   (Q),
        .Q_N (Q_N)
    );

    typedef struct {
        string tag;
        int    idx;
        logic  q;
        logic  qn;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    // Reference model: the stored bit as a plain integer 0/1.
    int m_q = 0;

    // Clock with period 20: falling edges at 10, 30, ... and rising edges at 20, 40, ...
    initial begin
        Clk = 1'b1;
        forever #10 Clk = ~Clk;
    end

    // Update the stored bit from the control levels now applied.
    task automatic model_async();
        if (R == 1'b0)      m_q = 0;
        else if (S == 1'b0) m_q = 1;
    endtask

    // Apply the J/K action for one falling edge, used only while both controls are inactive.
    task automatic model_edge();
        int code;
        code = 2 * int'(J) + int'(K);
        if (code == 1)      m_q = 0;
        else if (code == 2) m_q = 1;
        else if (code == 3) m_q = 1 - m_q;
    endtask

    // Compute the pins the part should show now, then queue that expectation for the monitor.
    task automatic expect_now(input string tag);
        exp_t e;
        e.tag = tag;
        e.idx = step_no;
        if (!R && !S) begin
            e.q = 1'b1; e.qn = 1'b1;
        end else if (!R) begin
            e.q = 1'b0; e.qn = 1'b1;
        end else if (!S) begin
            e.q = 1'b1; e.qn = 1'b0;
        end else begin
            e.q  = (m_q != 0);
            e.qn = (m_q == 0);
        end
        exp_q.push_back(e);
        -> sample_ev;
    endtask

    // Monitor: on each announcement, sample the DUT 1 ns later and compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            #1;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL monitor_underflow: no expectation queued, Q=%b Q_N=%b", Q, Q_N);
            end else begin
                e = exp_q.pop_front();
                if (Q !== e.q || Q_N !== e.qn) begin
                    n_fail++;
                    $display("FAIL %s step %0d: got Q=%b Q_N=%b, want Q=%b Q_N=%b",
                             e.tag, e.idx, Q, Q_N, e.q, e.qn);
                end
            end
        end
    end

    // One cycle: check after the rising edge, drive the inputs mid-cycle and check, then check after the falling edge.
    task automatic step(input logic r, input logic s, input logic j, input logic k);
        @(posedge Clk);
        #1 expect_now("after_rise");
        #3;
        R = r; S = s; J = j; K = k;
        model_async();
        #1 expect_now("async");
        @(negedge Clk);
        if (R && S) model_edge();
        else        model_async();
        #1 expect_now("after_fall");
        step_no++;
    endtask

    // Directed steps from the test plan: {R,S,J,K}.
    localparam int N_DIR = 25;
    logic [3:0] dir_tab [N_DIR] = '{
        4'b0111, 4'b0111, 4'b0111,                 // clear held; toggles must be ignored
        4'b1000, 4'b1100, 4'b1100, 4'b1100,        // preset, then hold over 3 edges
        4'b0100, 4'b1110, 4'b1101,                 // from Q=0: J sets, then K resets
        4'b1111, 4'b1111, 4'b1111, 4'b1111,        // toggle 1,0,1,0
        4'b0010, 4'b1110,                          // both low gives 1/1; release gives 0, then edge sets Q=1
        4'b0100, 4'b1111, 4'b1111,                 // start a toggle run from Q=0
        4'b0111, 4'b0111,                          // clear mid-toggle; edges are ignored
        4'b1111, 4'b1111, 4'b1111,                 // toggling resumes, first edge gives 1
        4'b1100
    };

    initial begin
        logic [3:0] v;
        logic       r, s;
        logic       prev_both_low;
        R = 1'b0; S = 1'b1; J = 1'b1; K = 1'b1;
        model_async();
        #1 expect_now("reset_initial");
        #4;

        for (int i = 0; i < N_DIR; i++) begin
            v = dir_tab[i];
            step(v[3], v[2], v[1], v[0]);
        end

        prev_both_low = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                r = 1'b1; s = 1'b1;
            end else begin
                r = 1'($urandom_range(0, 1));
                s = 1'($urandom_range(0, 1));
            end
            // Release both controls together after a both-low phase.
            if (prev_both_low && r && !s) s = 1'b1;
            prev_both_low = !r && !s;
            step(r, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        #20;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
